// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. A power-of-two write FIFO feeds a
// framer with a configurable data width, parity mode, stop-bit count and baud rate.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset; flushes the FIFO and aborts any frame
//   wr_en     write strobe, at most one entry per cycle
//   din       character to enqueue, sampled when wr_en=1
//   full      FIFO holds FIFO_DEPTH entries
//   empty     FIFO holds no entries
//   level     current FIFO occupancy
//   overflow  one-cycle pulse after a write was rejected because the FIFO was full
//   tx_out    registered serial line, idle high
//   busy      a frame is in flight or the FIFO is non-empty
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 19_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [DATA_BITS-1:0]                  din,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       level,
    output logic                                  overflow,
    output logic                                  tx_out,
    output logic                                  busy
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W   = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_accept;
    logic                 pop;
    logic [DATA_BITS-1:0] rd_data;

    // Framer
    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 baud_done;

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign overflow = overflow_q;
    assign tx_out  = tx_q;
    assign busy    = (state_q != StIdle) | ~empty;

    // Acceptance depends only on full, so a pop in the same cycle cannot make room.
    assign wr_accept = wr_en & ~full;
    assign rd_data   = mem_q[rd_ptr_q];
    assign baud_done = (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = wr_en & full;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_accept, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;
        tx_d       = 1'b1;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    // Capture the character and its parity at pop so the frame is
                    // immune to later FIFO or din activity.
                    pop        = 1'b1;
                    shift_d    = rd_data;
                    par_d      = (PARITY == 2) ? ~(^rd_data) : (^rd_data);
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            StParity: begin
                tx_d = par_q;
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = StStop;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            StStop: begin
                tx_d = 1'b1;
                // bit_cnt is reused to count stop bits.
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Storage is not reset; emptiness is defined by the pointers and level.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances at BAUD_DIV=10 (8N1, 8E1, 8O1, 7N2).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [3:0] wr;

    logic [3:0]      full_v, empty_v, ovf_v, tx_v, busy_v;
    logic [3:0][4:0] lvl_v;

    int n_tests = 0;
    int n_fail  = 0;

    logic cap_en = 1'b0;
    logic cap_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_8n1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[0]), .din(din),
        .full(full_v[0]), .empty(empty_v[0]), .level(lvl_v[0]),
        .overflow(ovf_v[0]), .tx_out(tx_v[0]), .busy(busy_v[0])
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_8e1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[1]), .din(din),
        .full(full_v[1]), .empty(empty_v[1]), .level(lvl_v[1]),
        .overflow(ovf_v[1]), .tx_out(tx_v[1]), .busy(busy_v[1])
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_8o1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[2]), .din(din),
        .full(full_v[2]), .empty(empty_v[2]), .level(lvl_v[2]),
        .overflow(ovf_v[2]), .tx_out(tx_v[2]), .busy(busy_v[2])
    );

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
        .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) u_7n2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr[3]), .din(din[6:0]),
        .full(full_v[3]), .empty(empty_v[3]), .level(lvl_v[3]),
        .overflow(ovf_v[3]), .tx_out(tx_v[3]), .busy(busy_v[3])
    );

    // Line capture of the 8N1 instance, one sample per cycle.
    always @(negedge clk) begin
        if (cap_en) cap_q.push_back(tx_v[0]);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bits[i] is the line level of bit period i, start bit first, stop bit(s) last.
    typedef struct {
        int unsigned sel;
        logic [7:0]  data;
        int unsigned nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t vecs[8];

    task automatic send_frame(input vec_t v);
        int bad;
        int nc;
        @(negedge clk);
        din       = v.data;
        wr[v.sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = '0;
        check("empty_after_write", int'(empty_v[v.sel]), 0);
        check("tx_idle_after_write", int'(tx_v[v.sel]), 1);
        @(negedge clk);
        check("tx_idle_pop_cycle", int'(tx_v[v.sel]), 1);
        check("busy_in_frame", int'(busy_v[v.sel]), 1);
        bad = 0;
        nc  = int'(v.nbits) * 10;
        for (int j = 0; j < nc; j++) begin
            @(negedge clk);
            if (tx_v[v.sel] != v.bits[j / 10]) bad++;
            if (j == nc - 2) check("busy_before_stop_end", int'(busy_v[v.sel]), 1);
            if (j == nc - 1) check("busy_after_stop_end", int'(busy_v[v.sel]), 0);
        end
        check("frame_bits", bad, 0);
        @(negedge clk);
        check("tx_idle_after_frame", int'(tx_v[v.sel]), 1);
        check("level_after_frame", int'(lvl_v[v.sel]), 0);
        check("empty_after_frame", int'(empty_v[v.sel]), 1);
    endtask

    initial begin
        int prev_st;
        int idx;
        int st;
        int lows;
        logic [7:0] d;

        vecs[0] = '{sel: 0, data: 8'hA5, nbits: 10, bits: 12'h34A};
        vecs[1] = '{sel: 0, data: 8'h00, nbits: 10, bits: 12'h200};
        vecs[2] = '{sel: 0, data: 8'hFF, nbits: 10, bits: 12'h3FE};
        vecs[3] = '{sel: 1, data: 8'h07, nbits: 11, bits: 12'h60E};
        vecs[4] = '{sel: 2, data: 8'h07, nbits: 11, bits: 12'h40E};
        vecs[5] = '{sel: 1, data: 8'h03, nbits: 11, bits: 12'h406};
        vecs[6] = '{sel: 2, data: 8'h03, nbits: 11, bits: 12'h606};
        vecs[7] = '{sel: 3, data: 8'h55, nbits: 10, bits: 12'h3AA};

        rst_n = 1'b0;
        wr    = '0;
        din   = '0;
        #12;
        check("rst_tx", int'(tx_v[0]), 1);
        check("rst_busy", int'(busy_v[0]), 0);
        check("rst_full", int'(full_v[0]), 0);
        check("rst_empty", int'(empty_v[0]), 1);
        check("rst_level", int'(lvl_v[0]), 0);
        check("rst_overflow", int'(ovf_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 18 back-to-back writes into a 16-deep FIFO; the first pop makes room for 17.
        wr[0] = 1'b1;
        din   = 8'h00;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            if (k == 0) cap_en = 1'b1;
            @(negedge clk);
            check("burst_level", int'(lvl_v[0]), (k == 0) ? 1 : ((k > 16) ? 16 : k));
            check("burst_full", int'(full_v[0]), (k >= 16) ? 1 : 0);
            check("burst_overflow", int'(ovf_v[0]), (k == 17) ? 1 : 0);
            if (k < 17) din = 8'(k + 1);
            else wr[0] = 1'b0;
        end
        @(negedge clk);
        check("overflow_one_cycle", int'(ovf_v[0]), 0);
        repeat (1760) @(negedge clk);
        cap_en = 1'b0;

        prev_st = 0;
        idx     = 0;
        for (int c = 0; c < 17; c++) begin
            st = -1;
            for (int i = idx; i < cap_q.size(); i++) begin
                if (cap_q[i] == 1'b0) begin
                    st = i;
                    break;
                end
            end
            if (st < 0 || st + 100 > cap_q.size()) begin
                check("burst_frame_found", 0, 1);
                break;
            end
            if (c == 0) check("burst_first_start", st, 2);
            else check("burst_frame_spacing", st - prev_st, 101);
            for (int b = 0; b < 8; b++) d[b] = cap_q[st + 15 + 10 * b];
            check("burst_order", int'(d), c);
            check("burst_stop", int'(cap_q[st + 95]), 1);
            prev_st = st;
            idx     = st + 100;
        end
        lows = 0;
        for (int i = idx; i < cap_q.size(); i++) if (cap_q[i] == 1'b0) lows++;
        check("burst_no_extra_frame", lows, 0);
        check("burst_drained_busy", int'(busy_v[0]), 0);
        check("burst_drained_level", int'(lvl_v[0]), 0);

        // Reset in data bit 3 of a frame with five characters still queued.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wr[0] = 1'b1;
            din   = 8'(8'h30 + k);
        end
        @(negedge clk);
        wr = '0;
        check("mid_level_queued", int'(lvl_v[0]), 5);
        repeat (41) @(negedge clk);
        check("mid_bit3_low", int'(tx_v[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", int'(tx_v[0]), 1);
        check("mid_rst_empty", int'(empty_v[0]), 1);
        check("mid_rst_level", int'(lvl_v[0]), 0);
        check("mid_rst_busy", int'(busy_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_v[0] == 1'b0) lows++;
        end
        check("mid_quiet_after_rst", lows, 0);
        check("mid_empty_after_rst", int'(empty_v[0]), 1);

        for (int i = 0; i < 8; i++) send_frame(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the Nexys-class board designs. It replaces the single-character, button-triggered transmitter path with an N-deep write FIFO feeding a configurable framer. The framer supports data width, parity mode, stop-bit count and baud rate as parameters. It sits between any byte producer (switch/button logic, a message ROM, a CPU bus bridge) and the board UART TX pin, and reports buffer status and overflow.

## Interface

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD_RATE, 19_200: line rate. BAUD_DIV = CLK_FREQ / BAUD_RATE, integer-truncated; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: write buffer entries; power of 2, ≥ 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe; one entry per cycle.
- din  input  DATA_BITS  character to enqueue, sampled when wr_en=1.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when a write is rejected.
- tx_out  output  1  serial line, idle high; registered.
- busy  output  1  high while a frame is in flight or FIFO non-empty.

## Operation

- Reset (asserted, asynchronous): tx_out=1, busy=0, full=0, empty=1, level=0, overflow=0. FIFO is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame immediately; the line returns high with no glitch low.
- Write: accepted iff wr_en=1 and full=0 in that cycle. A write while full is dropped and overflow pulses the next cycle. FIFO contents are unchanged.
- Simultaneous pop and write: accepted when not full; level is unchanged. A write in the same cycle as a pop from a full FIFO is still rejected, because acceptance depends only on full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. If empty=0, pop the head into a shift register and go to START.
  - START: tx_out=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, BAUD_DIV cycles each. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: for even parity the bit is the XOR of the data bits; for odd parity it is the inverted XOR. Lasts BAUD_DIV cycles.
  - STOP: tx_out=1 for STOP_BITS×BAUD_DIV cycles, then go to IDLE.
- Data is captured at pop. Later changes on din or in the FIFO do not affect the frame in flight.
- The baud counter counts 0..BAUD_DIV-1, restarts at each state entry, and wraps with no drift across bits. The bit counter is $clog2(DATA_BITS+1) wide.
- busy = (state≠IDLE) | ~empty.

## Timing

- Write into an empty FIFO with the FSM in IDLE at edge N:
  - empty falls after edge N.
  - Pop occurs at edge N+1.
  - tx_out goes low after edge N+2.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles.
- Back-to-back frames: exactly 1 clk of idle-high (the IDLE/pop cycle) between the end of STOP and the next START.
- full, empty and level update on the edge following the write or pop.
- overflow is high for exactly one cycle per rejected write.
- busy falls on the same edge where the FSM leaves STOP with an empty FIFO.

## Test plan

- Bench configuration: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10) unless noted.
- 8N1, write 0xA5 once:
  - tx_out low 2 cycles after the write, for 10 cycles.
  - Then 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - busy drops 100 cycles after the start edge.
- PARITY=1, write 0x07: parity bit = 1. With PARITY=2: parity bit = 0. Both frames are 110 cycles.
- FIFO_DEPTH=16, 18 consecutive writes 0x00..0x11:
  - 17 are accepted; full asserts after the 17th.
  - The 18th raises overflow for 1 cycle.
  - 0x00..0x10 are transmitted in order, with a 1-cycle gap between frames.
- STOP_BITS=2, DATA_BITS=7, write 0x55: frame is 100 cycles, with the stop interval high for 20 cycles; level returns to 0.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 5 entries queued. Required response:
  - tx_out=1 and empty=1 immediately.
  - After release, no transmission until a new write arrives.
